// File: rtl/row_accumulator_pkg.sv
// Shared types and constants for the attention-row accumulator.
package row_accumulator_pkg;

  localparam int VEC_LEN_DEF = 8;
  localparam int ELEM_W_DEF  = 16;
  localparam int ACC_W_DEF   = 24;
  localparam int COUNT_W_DEF = 8;

  // Element and packed-vector types at the default widths
  typedef logic signed [ELEM_W_DEF-1:0] elem_t;
  typedef logic signed [ACC_W_DEF-1:0]  acc_elem_t;
  typedef logic [VEC_LEN_DEF*ELEM_W_DEF-1:0] elem_vec_t;
  typedef logic [VEC_LEN_DEF*ACC_W_DEF-1:0]  acc_vec_t;

  // Signed clipping limits of one accumulator element
  localparam acc_elem_t ACC_MAX = {1'b0, {(ACC_W_DEF-1){1'b1}}};
  localparam acc_elem_t ACC_MIN = {1'b1, {(ACC_W_DEF-1){1'b0}}};

  // ACCUM: collecting terms of a row; HOLD: presenting the finished sum
  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_e;

endpackage

// File: rtl/row_accumulator_sat_add_vec.sv
// Element-wise signed adder: acc + sext(vec) with per-element clipping to the
// accumulator range, plus a flag raised when any element clipped.
module sat_add_vec #(
  parameter int VEC_LEN = 8,
  parameter int ELEM_W  = 16,
  parameter int ACC_W   = 24
) (
  input  logic [VEC_LEN*ACC_W-1:0]  acc_i,
  input  logic [VEC_LEN*ELEM_W-1:0] vec_i,
  output logic [VEC_LEN*ACC_W-1:0]  sum_o,
  output logic                      sat_o
);

  localparam logic [ACC_W-1:0] SAT_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] SAT_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  logic [VEC_LEN-1:0] clip;

  for (genvar g = 0; g < VEC_LEN; g++) begin : g_elem
    logic [ACC_W-1:0]  a;
    logic [ELEM_W-1:0] e;
    logic [ACC_W:0]    wide;
    logic              ovf;

    assign a = acc_i[g*ACC_W +: ACC_W];
    assign e = vec_i[g*ELEM_W +: ELEM_W];
    // One guard bit holds the exact sum since ELEM_W <= ACC_W
    assign wide = {a[ACC_W-1], a} + {{(ACC_W+1-ELEM_W){e[ELEM_W-1]}}, e};
    // Guard bit disagreeing with the top bit means the sum left the range;
    // the guard bit then carries the true sign of the result
    assign ovf = wide[ACC_W] ^ wide[ACC_W-1];
    assign sum_o[g*ACC_W +: ACC_W] = ovf ? (wide[ACC_W] ? SAT_MIN : SAT_MAX)
                                         : wide[ACC_W-1:0];
    assign clip[g] = ovf;
  end

  assign sat_o = |clip;

endmodule

// File: rtl/row_accumulator.sv
// Sums the vectors of one attention row into saturating accumulators and
// hands the finished sum downstream.
// Handshake: a transfer happens at a clock edge where valid and ready are
// both high; a valid source holds its data stable until that edge, and
// ready never depends combinationally on valid.
module row_accumulator
  import row_accumulator_pkg::*;
#(
  parameter int VEC_LEN = VEC_LEN_DEF,
  parameter int ELEM_W  = ELEM_W_DEF,
  parameter int ACC_W   = ACC_W_DEF,
  parameter int COUNT_W = COUNT_W_DEF
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      vld_in,
  output logic                      rdy_out,
  input  logic [VEC_LEN*ELEM_W-1:0] vec_in,
  input  logic                      last_in,
  output logic                      vld_out,
  input  logic                      rdy_in,
  output logic [VEC_LEN*ACC_W-1:0]  vec_out,
  output logic [COUNT_W-1:0]        count_out,
  output logic                      sat_out,
  output state_e                    state_o
);

  state_e                   state_q;
  logic [VEC_LEN*ACC_W-1:0] acc_q;
  logic [VEC_LEN*ACC_W-1:0] acc_d;
  logic [COUNT_W-1:0]       count_q;
  logic                     sat_q;
  logic                     sat_d;
  logic                     rdy_q;
  logic                     vld_q;
  logic                     accept;

  sat_add_vec #(
    .VEC_LEN (VEC_LEN),
    .ELEM_W  (ELEM_W),
    .ACC_W   (ACC_W)
  ) u_sat_add_vec (
    .acc_i (acc_q),
    .vec_i (vec_in),
    .sum_o (acc_d),
    .sat_o (sat_d)
  );

  // rdy_q is only ever high in ACCUM, so this is the accumulate condition
  assign accept = vld_in && rdy_q;

  // Row FSM with accumulator, saturating term counter, sticky clip flag and
  // registered handshake outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ACCUM;
      acc_q   <= '0;
      count_q <= '0;
      sat_q   <= 1'b0;
      rdy_q   <= 1'b1;
      vld_q   <= 1'b0;
    end else begin
      case (state_q)
        ACCUM: begin
          if (accept) begin
            acc_q   <= acc_d;
            count_q <= (&count_q) ? count_q : count_q + 1'b1;
            sat_q   <= sat_q | sat_d;
            if (last_in) begin
              state_q <= HOLD;
              rdy_q   <= 1'b0;
              vld_q   <= 1'b1;
            end
          end
        end
        HOLD: begin
          if (rdy_in) begin
            state_q <= ACCUM;
            acc_q   <= '0;
            count_q <= '0;
            sat_q   <= 1'b0;
            rdy_q   <= 1'b1;
            vld_q   <= 1'b0;
          end
        end
        default: begin
          state_q <= ACCUM;
          rdy_q   <= 1'b1;
          vld_q   <= 1'b0;
        end
      endcase
    end
  end

  assign rdy_out   = rdy_q;
  assign vld_out   = vld_q;
  assign vec_out   = acc_q;
  assign count_out = count_q;
  assign sat_out   = sat_q;
  assign state_o   = state_q;

endmodule

// File: tb/tb_row_accumulator.sv
// Directed bench for row_accumulator: reset, row sums, backpressure,
// saturation, single-term rows, mid-row reset and back-to-back streaming.
module tb_row_accumulator;
  import row_accumulator_pkg::*;

  localparam int VL = 8;
  localparam int EW = 16;
  localparam int AW = 24;
  localparam int CW = 8;

  logic               clk;
  logic               rst;
  logic               vld_in;
  logic               rdy_out;
  logic [VL*EW-1:0]   vec_in;
  logic               last_in;
  logic               vld_out;
  logic               rdy_in;
  logic [VL*AW-1:0]   vec_out;
  logic [CW-1:0]      count_out;
  logic               sat_out;
  state_e             dbg_state;

  int checks = 0;
  int errors = 0;

  logic [VL*AW-1:0] exp_q[$];

  row_accumulator dut (
    .clk       (clk),
    .rst       (rst),
    .vld_in    (vld_in),
    .rdy_out   (rdy_out),
    .vec_in    (vec_in),
    .last_in   (last_in),
    .vld_out   (vld_out),
    .rdy_in    (rdy_in),
    .vec_out   (vec_out),
    .count_out (count_out),
    .sat_out   (sat_out),
    .state_o   (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [VL*EW-1:0] splat_in(int v);
    logic [VL*EW-1:0] r;
    for (int i = 0; i < VL; i++) r[i*EW +: EW] = v[EW-1:0];
    return r;
  endfunction

  function automatic logic [VL*AW-1:0] splat_acc(int v);
    logic [VL*AW-1:0] r;
    for (int i = 0; i < VL; i++) r[i*AW +: AW] = v[AW-1:0];
    return r;
  endfunction

  // advance to just after the next active edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // drop a held result by pulsing rdy_in for one edge
  task automatic release_row();
    vld_in = 1'b0;
    rdy_in = 1'b1;
    step();
    rdy_in = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; vld_in = 1'b0; last_in = 1'b0; rdy_in = 1'b0; vec_in = '0;
    step(); step();
    rst = 1'b0;
    checks++; if (rdy_out !== 1'b1) begin errors++; $display("FAIL reset_rdy_out: got %b expected 1", rdy_out); end
    checks++; if (vld_out !== 1'b0) begin errors++; $display("FAIL reset_vld_out: got %b expected 0", vld_out); end
    checks++; if (vec_out !== '0) begin errors++; $display("FAIL reset_vec_out: got %h expected 0", vec_out); end
    checks++; if (count_out !== '0) begin errors++; $display("FAIL reset_count_out: got %0d expected 0", count_out); end
    checks++; if (sat_out !== 1'b0) begin errors++; $display("FAIL reset_sat_out: got %b expected 0", sat_out); end
  endtask

  task automatic test_three_term();
    vld_in = 1'b1; last_in = 1'b0; vec_in = splat_in(100);
    step();
    vec_in = splat_in(200);
    step();
    checks++; if (vld_out !== 1'b0) begin errors++; $display("FAIL three_vld_early: got %b expected 0", vld_out); end
    vec_in = splat_in(-50); last_in = 1'b1;
    step();
    vld_in = 1'b0; last_in = 1'b0;
    checks++; if (vld_out !== 1'b1) begin errors++; $display("FAIL three_vld_out: got %b expected 1", vld_out); end
    checks++; if (rdy_out !== 1'b0) begin errors++; $display("FAIL three_rdy_out: got %b expected 0", rdy_out); end
    checks++; if (vec_out !== splat_acc(250)) begin errors++; $display("FAIL three_vec_out: got %h expected %h", vec_out, splat_acc(250)); end
    checks++; if (count_out !== 8'd3) begin errors++; $display("FAIL three_count: got %0d expected 3", count_out); end
    checks++; if (sat_out !== 1'b0) begin errors++; $display("FAIL three_sat: got %b expected 0", sat_out); end
    release_row();
    checks++; if (vld_out !== 1'b0) begin errors++; $display("FAIL three_vld_after: got %b expected 0", vld_out); end
    checks++; if (rdy_out !== 1'b1) begin errors++; $display("FAIL three_rdy_after: got %b expected 1", rdy_out); end
    checks++; if (count_out !== 8'd0) begin errors++; $display("FAIL three_count_clear: got %0d expected 0", count_out); end
  endtask

  task automatic test_backpressure();
    vld_in = 1'b1; last_in = 1'b1; vec_in = splat_in(7); rdy_in = 1'b0;
    step();
    // next row's vector waits upstream while the result is held
    vec_in = splat_in(9);
    for (int i = 0; i < 5; i++) begin
      checks++; if (rdy_out !== 1'b0) begin errors++; $display("FAIL bp_rdy_out[%0d]: got %b expected 0", i, rdy_out); end
      checks++; if (vld_out !== 1'b1) begin errors++; $display("FAIL bp_vld_out[%0d]: got %b expected 1", i, vld_out); end
      checks++; if (vec_out !== splat_acc(7)) begin errors++; $display("FAIL bp_vec_out[%0d]: got %h expected %h", i, vec_out, splat_acc(7)); end
      step();
    end
    rdy_in = 1'b1;
    step();
    rdy_in = 1'b0;
    checks++; if (rdy_out !== 1'b1) begin errors++; $display("FAIL bp_rdy_resume: got %b expected 1", rdy_out); end
    checks++; if (vec_out !== '0) begin errors++; $display("FAIL bp_acc_clear: got %h expected 0", vec_out); end
    step();
    vld_in = 1'b0; last_in = 1'b0;
    checks++; if (vec_out !== splat_acc(9)) begin errors++; $display("FAIL bp_fresh_row: got %h expected %h", vec_out, splat_acc(9)); end
    checks++; if (count_out !== 8'd1) begin errors++; $display("FAIL bp_fresh_count: got %0d expected 1", count_out); end
    release_row();
  endtask

  task automatic test_saturation(input int elem, input int exp_elem);
    vld_in = 1'b1; last_in = 1'b0; vec_in = splat_in(elem);
    for (int i = 0; i < 299; i++) step();
    last_in = 1'b1;
    step();
    vld_in = 1'b0; last_in = 1'b0;
    checks++; if (vec_out !== splat_acc(exp_elem)) begin errors++; $display("FAIL sat_vec_out(%0d): got %h expected %h", elem, vec_out, splat_acc(exp_elem)); end
    checks++; if (sat_out !== 1'b1) begin errors++; $display("FAIL sat_flag(%0d): got %b expected 1", elem, sat_out); end
    checks++; if (count_out !== 8'd255) begin errors++; $display("FAIL sat_count(%0d): got %0d expected 255", elem, count_out); end
    release_row();
    checks++; if (sat_out !== 1'b0) begin errors++; $display("FAIL sat_flag_clear(%0d): got %b expected 0", elem, sat_out); end
  endtask

  task automatic test_single_term();
    logic [VL*AW-1:0] exp_v;
    for (int i = 0; i < VL; i++) begin
      vec_in[i*EW +: EW] = EW'(i);
      exp_v[i*AW +: AW]  = AW'(i);
    end
    vld_in = 1'b1; last_in = 1'b1;
    step();
    vld_in = 1'b0; last_in = 1'b0;
    checks++; if (vld_out !== 1'b1) begin errors++; $display("FAIL single_vld_out: got %b expected 1", vld_out); end
    checks++; if (vec_out !== exp_v) begin errors++; $display("FAIL single_vec_out: got %h expected %h", vec_out, exp_v); end
    checks++; if (count_out !== 8'd1) begin errors++; $display("FAIL single_count: got %0d expected 1", count_out); end
    release_row();
    // negative elements must sign-extend
    vec_in = splat_in(-3); vld_in = 1'b1; last_in = 1'b1;
    step();
    vld_in = 1'b0; last_in = 1'b0;
    checks++; if (vec_out !== splat_acc(-3)) begin errors++; $display("FAIL single_sext: got %h expected %h", vec_out, splat_acc(-3)); end
    release_row();
  endtask

  task automatic test_reset_mid_row();
    vld_in = 1'b1; last_in = 1'b0; vec_in = splat_in(1000);
    step(); step();
    vld_in = 1'b0;
    checks++; if (vec_out !== splat_acc(2000)) begin errors++; $display("FAIL midrst_partial: got %h expected %h", vec_out, splat_acc(2000)); end
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++; if (vec_out !== '0) begin errors++; $display("FAIL midrst_vec_clear: got %h expected 0", vec_out); end
    checks++; if (count_out !== 8'd0) begin errors++; $display("FAIL midrst_count_clear: got %0d expected 0", count_out); end
    vld_in = 1'b1; last_in = 1'b1; vec_in = splat_in(5);
    step();
    vld_in = 1'b0; last_in = 1'b0;
    checks++; if (vec_out !== splat_acc(5)) begin errors++; $display("FAIL midrst_vec_out: got %h expected %h", vec_out, splat_acc(5)); end
    checks++; if (count_out !== 8'd1) begin errors++; $display("FAIL midrst_count: got %0d expected 1", count_out); end
    // reset during HOLD drops the held result
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++; if (vld_out !== 1'b0) begin errors++; $display("FAIL hold_rst_vld: got %b expected 0", vld_out); end
  endtask

  task automatic test_back_to_back();
    int rows = 4;
    int beat = 0;
    int seen = 0;
    int idle = 0;
    int cycles = 0;
    logic rdy_now;
    exp_q.delete();
    rdy_in = 1'b1;
    while (seen < rows && cycles < 100) begin
      vld_in  = (beat < 2*rows);
      vec_in  = (beat % 2 == 0) ? splat_in((beat/2)*10 + 1) : splat_in(-((beat/2)*3));
      last_in = (beat % 2 == 1);
      rdy_now = rdy_out;
      if (!rdy_out) idle++;
      if (vld_out) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL b2b_unexpected: got %h expected no output", vec_out);
        end else begin
          logic [VL*AW-1:0] e;
          e = exp_q.pop_front();
          if (vec_out !== e) begin errors++; $display("FAIL b2b_row%0d_vec: got %h expected %h", seen, vec_out, e); end
        end
        checks++; if (count_out !== 8'd2) begin errors++; $display("FAIL b2b_row%0d_count: got %0d expected 2", seen, count_out); end
        seen++;
      end
      step();
      cycles++;
      if (vld_in && rdy_now) begin
        if (beat % 2 == 1) exp_q.push_back(splat_acc((beat/2)*10 + 1 - (beat/2)*3));
        beat++;
      end
    end
    vld_in = 1'b0; last_in = 1'b0; rdy_in = 1'b0;
    checks++; if (seen !== rows) begin errors++; $display("FAIL b2b_rows_seen: got %0d expected %0d", seen, rows); end
    checks++; if (idle !== rows) begin errors++; $display("FAIL b2b_idle_cycles: got %0d expected %0d", idle, rows); end
    checks++; if (cycles !== 3*rows) begin errors++; $display("FAIL b2b_total_cycles: got %0d expected %0d", cycles, 3*rows); end
  endtask

  initial begin
    test_reset();
    test_three_term();
    test_backpressure();
    test_saturation(32767, 8388607);
    test_saturation(-32768, -8388608);
    test_single_term();
    test_reset_mid_row();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
